// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell, registered carry, LSB first.
// A start accepted in IDLE runs N ADD cycles, then one DONE cycle.
// The result and the done pulse are registered on the DONE->IDLE edge.

// One-bit full-adder cell: o_y = {carry, sum} of a + b + c.
module sa_fa_cell (
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_c,
    output logic [1:0] o_y
);

    assign o_y = 2'(i_a) + 2'(i_b) + 2'(i_c);

endmodule

module serial_adder #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int unsigned CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [N-1:0]     r_a_sh;
    logic [N-1:0]     r_b_sh;
    logic [N-1:0]     r_s_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             r_busy;
    logic             r_done;
    logic [N-1:0]     r_sum;
    logic             r_cout;

    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_load;
    logic             w_step;
    logic [1:0]       w_y;

    // Operands are captured only when a start is accepted in IDLE.
    assign w_load = (r_state == S_IDLE) && start;
    assign w_step = (r_state == S_ADD);

    sa_fa_cell u_fa (
        .i_a (r_a_sh[0]),
        .i_b (r_b_sh[0]),
        .i_c (r_carry),
        .o_y (w_y)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and next-output decode; busy tracks residency in ADD.
    always_comb begin
        w_next_state = r_state;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_ADD;
                    w_busy_nxt   = 1'b1;
                end
            end
            S_ADD: begin
                if (r_cnt == LAST_CNT) begin
                    w_next_state = S_DONE;
                end else begin
                    w_busy_nxt   = 1'b1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
                w_done_nxt   = 1'b1;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Shift datapath: one bit of a + b + carry per ADD cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_a_sh  <= a_in;
            r_b_sh  <= b_in;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a_sh  <= {1'b0, r_a_sh[N-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[N-1:1]};
            r_s_sh  <= {w_y[0], r_s_sh[N-1:1]};
            r_carry <= w_y[1];
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Output registers; sum/cout only move together with the done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (r_state == S_DONE) begin
                r_sum  <= r_s_sh;
                r_cout <= r_carry;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit and a 4-bit instance, a timeline model
// checked every cycle, and directed cases with literal expectations.
module tb_serial_adder;

    logic       clk;
    logic       reset_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int n_cmp;
    int n_fail;

    // model state, index 0 = 8-bit instance, 1 = 4-bit instance
    int e;
    bit m_act  [2];
    int m_acc  [2];
    int m_res  [2];
    bit m_busy [2];
    bit m_done [2];
    int m_sum  [2];
    bit m_cout [2];

    serial_adder #(.N(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .a_in(a8), .b_in(b8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.N(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .a_in(a4), .b_in(b4),
        .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i]  = 1'b0;
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
            m_sum[i]  = 0;
            m_cout[i] = 1'b0;
        end
    endtask

    // Timeline model: accept at edge t, busy after edges t..t+W-1,
    // done and result after edge t+W+1, idle again for edge t+W+2.
    task automatic model_step();
        int w;
        bit st, was_idle;
        int opa, opb, opc;
        e = e + 1;
        for (int i = 0; i < 2; i++) begin
            w   = (i == 0) ? 8 : 4;
            st  = (i == 0) ? start8 : start4;
            opa = (i == 0) ? int'(a8) : int'(a4);
            opb = (i == 0) ? int'(b8) : int'(b4);
            opc = (i == 0) ? int'(cin8) : int'(cin4);
            was_idle  = !m_act[i];
            m_done[i] = 1'b0;
            if (m_act[i]) begin
                if (e == m_acc[i] + w) m_busy[i] = 1'b0;
                if (e == m_acc[i] + w + 1) begin
                    m_done[i] = 1'b1;
                    m_sum[i]  = m_res[i] % (1 << w);
                    m_cout[i] = ((m_res[i] >> w) != 0);
                    m_act[i]  = 1'b0;
                end
            end
            if (was_idle && st) begin
                m_act[i]  = 1'b1;
                m_acc[i]  = e;
                m_busy[i] = 1'b1;
                m_res[i]  = opa + opb + opc;
            end
        end
    endtask

    // 8-bit directed add with literal expectations; inj>0 pulses a stray start.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic eco, input int inj);
        int cyc, nbusy, ndone;
        bit seen;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        cyc = 0; nbusy = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start8 = 1'b0;
            if (cyc == 2) begin a8 = ~a; b8 = ~b; cin8 = ~c; end
            if (inj != 0 && cyc == inj) begin start8 = 1'b1; a8 = 8'hFF; end
            if (inj != 0 && cyc == inj + 1) start8 = 1'b0;
            if (busy8) nbusy++;
            if (done8) seen = 1'b1;
        end
        chk("done8_seen", int'(seen), 1);
        if (seen) begin
            chk("latency8", cyc - 1, 9);
            chk("busy8_cycles", nbusy, 8);
            chk("sum8_lit", int'(sum8), int'(es));
            chk("cout8_lit", int'(cout8), int'(eco));
        end
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("extra_done8", ndone, 0);
    endtask

    initial begin
        int ndone, cyc, exp;
        bit seen;
        n_cmp = 0; n_fail = 0; e = 0;
        reset_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        model_reset();

        fork
            forever begin
                @(posedge clk);
                #3;
                if (!reset_n) begin
                    model_reset();
                end else begin
                    model_step();
                    chk("busy8", int'(busy8), int'(m_busy[0]));
                    chk("done8", int'(done8), int'(m_done[0]));
                    chk("sum8", int'(sum8), m_sum[0]);
                    chk("cout8", int'(cout8), int'(m_cout[0]));
                    chk("busy4", int'(busy4), int'(m_busy[1]));
                    chk("done4", int'(done4), int'(m_done[1]));
                    chk("sum4", int'(sum4), m_sum[1]);
                    chk("cout4", int'(cout4), int'(m_cout[1]));
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_busy8", int'(busy8), 0);
        chk("rst_done8", int'(done8), 0);
        chk("rst_sum8", int'(sum8), 0);
        chk("rst_cout8", int'(cout8), 0);
        chk("rst_busy4", int'(busy4), 0);
        chk("rst_done4", int'(done4), 0);
        reset_n = 1'b1;

        run8(8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0, 0);
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
        run8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3);

        // Reset dropped in the fourth ADD cycle must clear everything at once.
        @(negedge clk);
        a8 = 8'h37; b8 = 8'h48; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy8", int'(busy8), 1);
        reset_n = 1'b0;
        #1;
        chk("abort_busy8", int'(busy8), 0);
        chk("abort_done8", int'(done8), 0);
        chk("abort_sum8", int'(sum8), 0);
        chk("abort_cout8", int'(cout8), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("abort_no_done8", ndone, 0);
        run8(8'h37, 8'h48, 1'b1, 8'h80, 1'b0, 0);

        // Exhaustive 4-bit sweep with start held high.
        @(negedge clk);
        a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0; start4 = 1'b1;
        for (int idx = 0; idx < 512; idx++) begin
            exp = (idx % 16) + ((idx / 16) % 16) + (idx / 256);
            cyc = 0; seen = 1'b0;
            while (!seen && cyc < 20) begin
                @(negedge clk);
                cyc++;
                if (done4) seen = 1'b1;
            end
            chk("sweep_done4", int'(seen), 1);
            chk("sweep_sum4", int'(sum4), exp % 16);
            chk("sweep_cout4", int'(cout4), exp / 16);
            chk("sweep_gap4", cyc, 6);
            if (idx < 511) begin
                a4   = 4'((idx + 1) % 16);
                b4   = 4'(((idx + 1) / 16) % 16);
                cin4 = ((idx + 1) / 256) != 0;
            end
        end
        start4 = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
